// File: rtl/half_adder_bist_pkg.sv
// Shared types and helpers for the half-adder built-in self-test engine.
// Response encoding throughout is {sum, carry}.
package half_adder_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StReport
    } bist_state_e;

    localparam int unsigned NUM_VECTORS = 4;
    localparam logic [7:0]  ERR_MAX     = 8'hFF;

    // Golden half-adder response for operand pair vec = {a, b}.
    function automatic logic [1:0] exp_resp(input logic [1:0] vec);
        return {vec[1] ^ vec[0], vec[1] & vec[0]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == ERR_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/ha_bist_vec_gen.sv
// Vector sequencer: steps {a,b} through 00..11, holding each for RESP_LAT+1 cycles,
// and flags the cycle whose closing edge samples the adder response.
module ha_bist_vec_gen
    import half_adder_bist_pkg::*;
#(
    parameter int unsigned RESP_LAT   = 0,
    parameter int unsigned NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    output logic [1:0] vec,
    output logic       cmp_strobe,
    output logic       last_cmp
);

    localparam logic [2:0] HoldLast = 3'(RESP_LAT);
    localparam logic [7:0] PassLast = 8'(NUM_PASSES - 1);
    localparam logic [1:0] VecLast  = 2'(NUM_VECTORS - 1);

    logic [1:0] vec_idx_q, vec_idx_d;
    logic [2:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;

    assign cmp_strobe = run && (hold_cnt_q == HoldLast);
    assign last_cmp   = cmp_strobe && (vec_idx_q == VecLast) && (pass_cnt_q == PassLast);

    // vec_idx wrapping 3->0 on the final compare is what returns the operands to 0.
    assign vec = vec_idx_q;

    always_comb begin
        vec_idx_d  = vec_idx_q;
        hold_cnt_d = hold_cnt_q;
        pass_cnt_d = pass_cnt_q;
        if (clear) begin
            vec_idx_d  = 2'd0;
            hold_cnt_d = 3'd0;
            pass_cnt_d = 8'd0;
        end else if (cmp_strobe) begin
            hold_cnt_d = 3'd0;
            vec_idx_d  = vec_idx_q + 2'd1;
            if (vec_idx_q == VecLast) begin
                pass_cnt_d = pass_cnt_q + 8'd1;
            end
        end else if (run) begin
            hold_cnt_d = hold_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx_q  <= 2'd0;
            hold_cnt_q <= 3'd0;
            pass_cnt_q <= 8'd0;
        end else begin
            vec_idx_q  <= vec_idx_d;
            hold_cnt_q <= hold_cnt_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

endmodule

// File: rtl/half_adder_bist.sv
// Self-test engine for the half-adder core: sweeps all operand pairs, checks sum/carry,
// and reports pass/fail, a saturating mismatch count and a sticky per-vector failure map.
module half_adder_bist
    import half_adder_bist_pkg::*;
#(
    parameter int unsigned RESP_LAT   = 0,
    parameter int unsigned NUM_PASSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_sum,
    input  logic       dut_carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    bist_state_e state_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [7:0]  err_count_q;
    logic [3:0]  fail_vec_q;

    logic        accept;
    logic        run;
    logic [1:0]  vec;
    logic        cmp_strobe;
    logic        last_cmp;
    logic        mismatch;
    logic [7:0]  err_count_d;

    assign accept = (state_q == StIdle) && start;
    assign run    = (state_q == StRun);

    ha_bist_vec_gen #(
        .RESP_LAT   (RESP_LAT),
        .NUM_PASSES (NUM_PASSES)
    ) u_vec_gen (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .run        (run),
        .vec        (vec),
        .cmp_strobe (cmp_strobe),
        .last_cmp   (last_cmp)
    );

    // Any wrong response bit counts as a single mismatch.
    always_comb begin
        mismatch    = cmp_strobe && ({dut_sum, dut_carry} != exp_resp(vec));
        err_count_d = mismatch ? sat_inc(err_count_q) : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 8'd0;
            fail_vec_q  <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        err_count_q <= 8'd0;
                        fail_vec_q  <= 4'd0;
                    end
                end
                StRun: begin
                    if (cmp_strobe) begin
                        err_count_q <= err_count_d;
                        if (mismatch) begin
                            fail_vec_q[vec] <= 1'b1;
                        end
                        if (last_cmp) begin
                            state_q <= StReport;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == 8'd0);
                        end
                    end
                end
                StReport: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dut_a     = vec[1];
    assign dut_b     = vec[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule
